// File: rtl/approx_sweep_pkg.sv
// Shared types and helpers for exhaustive approximate-circuit error sweepers.
package approx_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sweep_state_t;

  // Callers zero-extend operands to this width and truncate the result to their own width.
  localparam int unsigned AbsErrMaxW = 32;

  function automatic logic [AbsErrMaxW-1:0] abs_err(input logic [AbsErrMaxW-1:0] a,
                                                     input logic [AbsErrMaxW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/abs_err_unit.sv
// Combinational absolute difference of two unsigned responses plus the threshold compare.
module abs_err_unit
  import approx_sweep_pkg::*;
#(
  parameter int unsigned W  = 3,
  parameter int unsigned ET = 1
) (
  input  logic [W-1:0] exact_i,
  input  logic [W-1:0] approx_i,
  output logic [W-1:0] err_o,
  output logic         viol_o
);

  assign err_o  = W'(abs_err(AbsErrMaxW'(exact_i), AbsErrMaxW'(approx_i)));
  assign viol_o = (32'(err_o) > ET);

endmodule

// File: rtl/approx_error_sweeper.sv
// Sweeps every input vector through an approximate circuit and gathers error statistics.
// Define SWEEP_ERR_SUM_EN to add the err_sum_o accumulator output.
module approx_error_sweeper
  import approx_sweep_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned ET    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [N_IN-1:0]       vec_out_o,
  input  logic [N_OUT-1:0]      approx_in_i,
  input  logic [N_OUT-1:0]      exact_in_i,
  output logic [N_OUT-1:0]      max_err_o,
  output logic [N_IN:0]         viol_cnt_o,
  output logic [N_IN-1:0]       first_viol_o,
  output logic                  first_viol_vld_o,
  output logic                  pass_o
`ifdef SWEEP_ERR_SUM_EN
  ,
  output logic [N_OUT+N_IN-1:0] err_sum_o
`endif
);

  localparam logic [N_IN-1:0] VecMax = '1;
  localparam logic [N_IN:0]   CntMax = (N_IN+1)'(2**N_IN);

  sweep_state_t state_q, state_d;

  logic [N_IN-1:0]  vec_q, vec_d;
  logic [N_IN-1:0]  vec_p_q;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [N_OUT-1:0] max_err_q, max_err_d;
  logic [N_IN:0]    viol_cnt_q, viol_cnt_d;
  logic [N_IN-1:0]  first_viol_q, first_viol_d;
  logic             fv_vld_q, fv_vld_d;
  logic [N_OUT-1:0] err;
  logic             viol;
  logic             clr;

  abs_err_unit #(
    .W  (N_OUT),
    .ET (ET)
  ) u_abs_err (
    .exact_i  (exact_in_i),
    .approx_i (approx_in_i),
    .err_o    (err),
    .viol_o   (viol)
  );

  // Results clear on an accepted start and on any abort.
  assign clr = abort_i | ((state_q == StIdle) & start_i);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (vec_q == VecMax) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i) state_d = StIdle;
  end

  always_comb begin
    vec_d        = vec_q;
    vld_d        = (state_q == StRun) & ~abort_i;
    done_d       = (state_q == StDone) & ~abort_i;
    pass_d       = pass_q;
    max_err_d    = max_err_q;
    viol_cnt_d   = viol_cnt_q;
    first_viol_d = first_viol_q;
    fv_vld_d     = fv_vld_q;
    if (clr) begin
      vec_d        = '0;
      pass_d       = 1'b0;
      max_err_d    = '0;
      viol_cnt_d   = '0;
      first_viol_d = '0;
      fv_vld_d     = 1'b0;
    end else begin
      // Counter saturates at all-ones so the last vector holds through DRAIN.
      if (state_q == StRun && vec_q != VecMax) vec_d = vec_q + N_IN'(1);
      if (state_q == StDone) pass_d = (viol_cnt_q == '0);
      if (vld_q) begin
        if (err > max_err_q) max_err_d = err;
        if (viol) begin
          if (viol_cnt_q != CntMax) viol_cnt_d = viol_cnt_q + (N_IN+1)'(1);
          if (!fv_vld_q) begin
            first_viol_d = vec_p_q;
            fv_vld_d     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      vec_p_q      <= '0;
      vld_q        <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      max_err_q    <= '0;
      viol_cnt_q   <= '0;
      first_viol_q <= '0;
      fv_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      vec_p_q      <= vec_q;
      vld_q        <= vld_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      max_err_q    <= max_err_d;
      viol_cnt_q   <= viol_cnt_d;
      first_viol_q <= first_viol_d;
      fv_vld_q     <= fv_vld_d;
    end
  end

`ifdef SWEEP_ERR_SUM_EN
  logic [N_OUT+N_IN-1:0] err_sum_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      err_sum_q <= '0;
    end else if (vld_q) begin
      err_sum_q <= err_sum_q + (N_OUT+N_IN)'(err);
    end
  end

  assign err_sum_o = err_sum_q;
`endif

  assign busy_o           = (state_q == StRun) | (state_q == StDrain);
  assign done_o           = done_q;
  assign vec_out_o        = vec_q;
  assign max_err_o        = max_err_q;
  assign viol_cnt_o       = viol_cnt_q;
  assign first_viol_o     = first_viol_q;
  assign first_viol_vld_o = fv_vld_q;
  assign pass_o           = pass_q;

endmodule
